occ_req_arbiter: RTL

Shares the single occurrence-table memory read port between the backward-extension request stage (requester A, the k/l interval stage) and the forward-extension request stage (requester B). Each requester presents one k/l address pair per transaction. The arbiter accepts one pair at a time, round-robin, and serialises it into one or two memory read beats, merging them when both addresses hit the same line. It back-pressures each stage through a stall line and bounds reads in flight with a credit counter.

---
 rtl/occ_req_arbiter_if.sv | 46 ++++
 rtl/occ_req_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/occ_req_arbiter_if.sv
// occ_req_arbiter_if: bundles the two requester channels, the memory read
// channel and the status outputs of occ_req_arbiter.
//   slave  : arbiter side (requester inputs, memory/status outputs)
//   master : environment side (drives requests and memory handshake)
interface occ_req_arbiter_if #(
  parameter int ADDR_W = 42,
  parameter int TAG_W  = 9,
  parameter int CNT_W  = 5
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr_k;
  logic [ADDR_W-1:0] a_addr_l;
  logic [TAG_W-1:0]  a_read_num;
  logic              a_stall;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr_k;
  logic [ADDR_W-1:0] b_addr_l;
  logic [TAG_W-1:0]  b_read_num;
  logic              b_stall;
  logic              mem_rd_valid;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [TAG_W+2:0]  mem_rd_tag;
  logic              mem_rd_ready;
  logic              mem_rsp_valid;
  logic [CNT_W-1:0]  outstanding;
  logic              busy;
  logic              underflow_err;

  modport slave (
    input  a_valid, a_addr_k, a_addr_l, a_read_num,
    input  b_valid, b_addr_k, b_addr_l, b_read_num,
    input  mem_rd_ready, mem_rsp_valid,
    output a_stall, b_stall,
    output mem_rd_valid, mem_rd_addr, mem_rd_tag,
    output outstanding, busy, underflow_err
  );

  modport master (
    output a_valid, a_addr_k, a_addr_l, a_read_num,
    output b_valid, b_addr_k, b_addr_l, b_read_num,
    output mem_rd_ready, mem_rsp_valid,
    input  a_stall, b_stall,
    input  mem_rd_valid, mem_rd_addr, mem_rd_tag,
    input  outstanding, busy, underflow_err
  );
endinterface

// File: rtl/occ_req_arbiter.sv
// occ_req_arbiter: shares one occurrence-table read port between requester A
// (backward extension) and requester B (forward extension). One k/l pair is
// accepted at a time, round-robin, and issued as one merged beat (k == l) or
// two beats (k then l). A credit counter bounds reads in flight.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : occ_req_arbiter_if.slave (requesters, memory read, status)
module occ_req_arbiter #(
  parameter int ADDR_W  = 42,
  parameter int TAG_W   = 9,
  parameter int MAX_OUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  occ_req_arbiter_if.slave bus
);

  // State encoding doubles as the tag "kind" field: K=01, L=10, merged=11.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SEND_K  = 2'b01,
    ST_SEND_L  = 2'b10,
    ST_SEND_KL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  state_t            r_state;
  logic              r_src;      // 0 = A, 1 = B
  logic              r_rr_ptr;   // requester favoured on contention
  logic [ADDR_W-1:0] r_addr_k;
  logic [ADDR_W-1:0] r_addr_l;
  logic [TAG_W-1:0]  r_num;
  logic [CNT_W-1:0]  r_outstanding;
  logic              r_underflow;

  logic              w_credit_ok;
  logic              w_rd_valid;
  logic              w_fire;
  logic              w_load_en;
  logic              w_grant_a;
  logic              w_grant_b;
  logic [ADDR_W-1:0] w_sel_k;
  logic [ADDR_W-1:0] w_sel_l;
  logic [TAG_W-1:0]  w_sel_num;

  assign w_credit_ok = (r_outstanding < MAX_OUT_C);
  assign w_rd_valid  = (r_state != ST_IDLE) & w_credit_ok;
  assign w_fire      = w_rd_valid & bus.mem_rd_ready;
  // A new pair may be taken when idle or in the same cycle the last beat fires.
  assign w_load_en   = (r_state == ST_IDLE) |
                       (w_fire & ((r_state == ST_SEND_L) | (r_state == ST_SEND_KL)));
  assign w_grant_a   = w_load_en & ~rst & bus.a_valid & (~bus.b_valid | ~r_rr_ptr);
  assign w_grant_b   = w_load_en & ~rst & bus.b_valid & (~bus.a_valid |  r_rr_ptr);

  assign w_sel_k     = w_grant_a ? bus.a_addr_k   : bus.b_addr_k;
  assign w_sel_l     = w_grant_a ? bus.a_addr_l   : bus.b_addr_l;
  assign w_sel_num   = w_grant_a ? bus.a_read_num : bus.b_read_num;

  assign bus.a_stall       = bus.a_valid & ~w_grant_a;
  assign bus.b_stall       = bus.b_valid & ~w_grant_b;
  assign bus.mem_rd_valid  = w_rd_valid;
  assign bus.mem_rd_addr   = (r_state == ST_SEND_L) ? r_addr_l : r_addr_k;
  assign bus.mem_rd_tag    = {r_src, r_state, r_num};
  assign bus.outstanding   = r_outstanding;
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.underflow_err = r_underflow;

  // Request FSM: arbitration, pair capture and beat sequencing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_src    <= 1'b0;
      r_rr_ptr <= 1'b0;
      r_addr_k <= '0;
      r_addr_l <= '0;
      r_num    <= '0;
    end else if (w_load_en) begin
      if (w_grant_a | w_grant_b) begin
        r_src    <= w_grant_b;
        r_rr_ptr <= ~w_grant_b;  // point at the requester not just served
        r_addr_k <= w_sel_k;
        r_addr_l <= w_sel_l;
        r_num    <= w_sel_num;
        r_state  <= (w_sel_k == w_sel_l) ? ST_SEND_KL : ST_SEND_K;
      end else begin
        r_state  <= ST_IDLE;
      end
    end else if ((r_state == ST_SEND_K) && w_fire) begin
      r_state <= ST_SEND_L;
    end else begin
      r_state <= r_state;
    end
  end

  // Reads-in-flight counter and sticky underflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_underflow   <= 1'b0;
    end else begin
      case ({w_fire, bus.mem_rsp_valid})
        2'b10: r_outstanding <= r_outstanding + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01: begin
          if (r_outstanding == '0) begin
            r_underflow <= 1'b1;
          end else begin
            r_outstanding <= r_outstanding - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
